axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_pkg.sv | 25 ++
 rtl/axi_watchdog.sv | 30 +++
 rtl/axi_burst_master.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI4 write-then-read burst tester.
package axi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // err_flags = {timeout, rlast_err, rresp_err, bresp_err}
  localparam int unsigned ERR_W       = 4;
  localparam int unsigned ERR_BRESP   = 0;
  localparam int unsigned ERR_RRESP   = 1;
  localparam int unsigned ERR_RLAST   = 2;
  localparam int unsigned ERR_TIMEOUT = 3;

  localparam int unsigned ID_W = 4;

endpackage

// File: rtl/axi_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// expiry in the cycle the count reaches TIMEOUT.
module axi_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Combinational so the owner can react on the very edge the budget runs out.
  assign expired = enable && !clear && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || clear || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 burst tester: writes an incrementing pattern, reads it back, and
// reports response/last/timeout errors plus the start-to-done cycle count.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 512,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [7:0]          burst_len,
  output logic                busy,
  output logic                done,
  output logic [ERR_W-1:0]    err_flags,
  output logic [31:0]         cycles,

  output logic [ID_W-1:0]     M_AXI_AWID,
  output logic [AW-1:0]       M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic                M_AXI_AWLOCK,
  output logic [3:0]          M_AXI_AWCACHE,
  output logic [2:0]          M_AXI_AWPROT,
  output logic [3:0]          M_AXI_AWQOS,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,

  output logic [DW-1:0]       M_AXI_WDATA,
  output logic [DW/8-1:0]     M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,

  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,

  output logic [ID_W-1:0]     M_AXI_ARID,
  output logic [AW-1:0]       M_AXI_ARADDR,
  output logic [7:0]          M_AXI_ARLEN,
  output logic [2:0]          M_AXI_ARSIZE,
  output logic [1:0]          M_AXI_ARBURST,
  output logic                M_AXI_ARLOCK,
  output logic [3:0]          M_AXI_ARCACHE,
  output logic [2:0]          M_AXI_ARPROT,
  output logic [3:0]          M_AXI_ARQOS,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,

  input  logic [DW-1:0]       M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RLAST,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam int unsigned NWORD    = DW / 32;
  localparam logic [2:0]  AXI_SIZE = 3'($clog2(DW / 8));

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q;
  logic [7:0]      beat;
  logic [31:0]     word_q;
  logic            aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic any_hs, wd_enable, wd_expired;
  logic unused_rdata;

  assign aw_hs  = aw_valid && M_AXI_AWREADY;
  assign w_hs   = w_valid  && M_AXI_WREADY;
  assign b_hs   = b_ready  && M_AXI_BVALID;
  assign ar_hs  = ar_valid && M_AXI_ARREADY;
  assign r_hs   = r_ready  && M_AXI_RVALID;
  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  assign wd_enable    = (state != ST_IDLE);
  assign unused_rdata = ^M_AXI_RDATA;

  axi_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable  (wd_enable),
    .clear   (any_hs),
    .expired (wd_expired)
  );

  // Read and write address channels share the latched burst description.
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = AXI_SIZE;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = '0;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWVALID = aw_valid;

  assign M_AXI_WDATA   = {NWORD{word_q}};
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = w_last;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_BREADY  = b_ready;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = AXI_SIZE;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARVALID = ar_valid;
  assign M_AXI_RREADY  = r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat      <= '0;
      word_q    <= '0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
      b_ready   <= 1'b0;
      ar_valid  <= 1'b0;
      r_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_flags <= '0;
      cycles    <= '0;
    end else begin
      done <= 1'b0;
      if (busy && (cycles != 32'hFFFF_FFFF)) begin
        cycles <= cycles + 32'd1;
      end

      if (wd_expired) begin
        // A stuck phase abandons the test; all handshakes are withdrawn.
        aw_valid               <= 1'b0;
        w_valid                <= 1'b0;
        w_last                 <= 1'b0;
        b_ready                <= 1'b0;
        ar_valid               <= 1'b0;
        r_ready                <= 1'b0;
        busy                   <= 1'b0;
        done                   <= 1'b1;
        err_flags[ERR_TIMEOUT] <= 1'b1;
        state                  <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              addr_q    <= base_addr;
              len_q     <= burst_len;
              err_flags <= '0;
              cycles    <= '0;
              aw_valid  <= 1'b1;
              busy      <= 1'b1;
              state     <= ST_AW;
            end
          end
          ST_AW: begin
            if (aw_hs) begin
              aw_valid <= 1'b0;
              w_valid  <= 1'b1;
              beat     <= '0;
              word_q   <= addr_q[31:0];
              w_last   <= (len_q == 8'd0);
              state    <= ST_W;
            end
          end
          ST_W: begin
            if (w_hs) begin
              if (beat == len_q) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
                b_ready <= 1'b1;
                state   <= ST_B;
              end else begin
                beat   <= beat + 8'd1;
                word_q <= word_q + 32'd1;
                w_last <= ((beat + 8'd1) == len_q);
              end
            end
          end
          ST_B: begin
            if (b_hs) begin
              b_ready <= 1'b0;
              if (M_AXI_BRESP != RESP_OKAY) begin
                err_flags[ERR_BRESP] <= 1'b1;
              end
              ar_valid <= 1'b1;
              state    <= ST_AR;
            end
          end
          ST_AR: begin
            if (ar_hs) begin
              ar_valid <= 1'b0;
              r_ready  <= 1'b1;
              beat     <= '0;
              state    <= ST_R;
            end
          end
          ST_R: begin
            // Beat count, not RLAST, ends the read so a bad RLAST is only flagged.
            if (r_hs) begin
              if (M_AXI_RRESP != RESP_OKAY) begin
                err_flags[ERR_RRESP] <= 1'b1;
              end
              if (M_AXI_RLAST != (beat == len_q)) begin
                err_flags[ERR_RLAST] <= 1'b1;
              end
              if (beat == len_q) begin
                r_ready <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= ST_IDLE;
              end else begin
                beat <= beat + 8'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: reactive AXI slave with a scoreboard of expected
// address-channel and write-beat payloads.
module tb_axi_burst_master;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic reset, start;
  logic [AW-1:0] base_addr;
  logic [7:0] burst_len;
  logic busy, done;
  logic [3:0] err_flags;
  logic [31:0] cycles;

  logic [3:0] M_AXI_AWID, M_AXI_AWCACHE, M_AXI_AWQOS, M_AXI_ARID, M_AXI_ARCACHE, M_AXI_ARQOS;
  logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_AWSIZE, M_AXI_ARSIZE;
  logic M_AXI_AWLOCK, M_AXI_ARLOCK;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [7:0] M_AXI_AWLEN, M_AXI_ARLEN;
  logic [1:0] M_AXI_AWBURST, M_AXI_ARBURST;
  logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
  logic M_AXI_BVALID, M_AXI_BREADY;
  logic M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  always #5 clk = ~clk;

  axi_burst_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .burst_len(burst_len),
    .busy(busy), .done(done), .err_flags(err_flags), .cycles(cycles),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int errors = 0;
  int checks = 0;

  // Slave behaviour knobs
  int stall;
  logic [1:0] bresp_val, rresp_val;
  bit rlast_all, awready_never, extra_start;
  int reset_beat;

  // Per-transaction observations
  int done_cnt, done_at, aw_first, busy_cnt, r_beats;
  logic [3:0] flags_seen;
  logic [31:0] cycles_seen;
  bit reset_hit;

  typedef struct packed { logic [31:0] word; logic last; } wexp_t;
  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } aexp_t;
  wexp_t exp_w[$];
  aexp_t exp_aw[$];
  aexp_t exp_ar[$];

  task automatic set_defaults();
    stall = 0; bresp_val = 2'b00; rresp_val = 2'b00;
    rlast_all = 0; awready_never = 0; extra_start = 0; reset_beat = -1;
  endtask

  task automatic idle_slave();
    start = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
  endtask

  // Starts one test and plays the slave cycle by cycle until done (+2 cycles).
  task automatic run_txn(input logic [AW-1:0] base, input logic [7:0] blen, input int max_cycles);
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0, r_beat = 0, w_beats = 0;
    bit b_pending = 0, r_pending = 0, aw_stl = 0, w_stl = 0, ar_stl = 0;
    logic [AW-1:0] aw_addr_p, ar_addr_p;
    logic [DW-1:0] wdata_p, exp_data;
    logic wlast_p;
    aexp_t ea;
    wexp_t ew;
    exp_aw.delete(); exp_ar.delete(); exp_w.delete();
    exp_aw.push_back('{addr: base, len: blen});
    exp_ar.push_back('{addr: base, len: blen});
    for (int i = 0; i <= int'(blen); i++)
      exp_w.push_back('{word: base[31:0] + 32'(i), last: (i == int'(blen))});
    done_cnt = 0; done_at = -1; aw_first = -1; busy_cnt = 0; r_beats = 0;
    flags_seen = '0; cycles_seen = '0; reset_hit = 0;
    aw_addr_p = '0; ar_addr_p = '0; wdata_p = '0; wlast_p = 1'b0;

    @(negedge clk);
    start = 1'b1; base_addr = base; burst_len = blen;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin start = 1'b0; base_addr = ~base; burst_len = ~blen; end
      if (extra_start && cyc == 3) begin start = 1'b1; base_addr = 64'hDEAD_BEEF_0000_0000; burst_len = 8'd5; end
      if (extra_start && cyc == 4) start = 1'b0;
      if (reset_beat >= 0 && M_AXI_WVALID && w_beats == reset_beat) begin
        reset = 1'b1; reset_hit = 1; break;
      end
      if (done) begin done_cnt++; done_at = cyc; flags_seen = err_flags; cycles_seen = cycles; end
      if (busy) busy_cnt++;
      if (done_at >= 0 && cyc >= done_at + 2) break;

      // B response, delayed by the stall budget after the last write beat
      if (b_pending && b_wait < stall) begin b_wait++; M_AXI_BVALID = 1'b0; end
      else M_AXI_BVALID = b_pending;
      M_AXI_BRESP = bresp_val;
      if (M_AXI_BVALID && M_AXI_BREADY) b_pending = 0;

      // R beats, delayed by the stall budget after the AR handshake
      if (r_pending && r_wait < stall) begin r_wait++; M_AXI_RVALID = 1'b0; end
      else M_AXI_RVALID = r_pending;
      M_AXI_RRESP = rresp_val;
      M_AXI_RLAST = rlast_all || (r_beat == int'(blen));
      M_AXI_RDATA = {(DW/32){32'(r_beat)}};
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        r_beats++; r_beat++;
        if (r_beat > int'(blen)) r_pending = 0;
      end

      // AW channel
      if (aw_stl && !done) begin
        checks++;
        if (!M_AXI_AWVALID || M_AXI_AWADDR !== aw_addr_p) begin
          errors++;
          $display("FAIL aw_stable: valid=%b addr=%h required valid=1 addr=%h", M_AXI_AWVALID, M_AXI_AWADDR, aw_addr_p);
        end
      end
      M_AXI_AWREADY = M_AXI_AWVALID && !awready_never && (aw_wait >= stall);
      if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_wait++;
      if (M_AXI_AWVALID && aw_first < 0) aw_first = cyc;
      aw_stl = M_AXI_AWVALID && !M_AXI_AWREADY;
      aw_addr_p = M_AXI_AWADDR;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        checks++;
        if (exp_aw.size() == 0) begin
          errors++; $display("FAIL aw_extra: unexpected AW handshake addr=%h", M_AXI_AWADDR);
        end else begin
          ea = exp_aw.pop_front();
          if ({M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST} !== {ea.addr, ea.len, 3'd6, 2'b01}) begin
            errors++;
            $display("FAIL aw_payload: got addr=%h len=%0d size=%0d burst=%0d required addr=%h len=%0d size=6 burst=1",
                     M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, ea.addr, ea.len);
          end
        end
      end

      // W channel
      if (w_stl && !done) begin
        checks++;
        if (!M_AXI_WVALID || M_AXI_WDATA !== wdata_p || M_AXI_WLAST !== wlast_p) begin
          errors++;
          $display("FAIL w_stable: valid=%b word0=%h last=%b required valid=1 word0=%h last=%b",
                   M_AXI_WVALID, M_AXI_WDATA[31:0], M_AXI_WLAST, wdata_p[31:0], wlast_p);
        end
      end
      M_AXI_WREADY = M_AXI_WVALID && (w_wait >= stall);
      if (M_AXI_WVALID && !M_AXI_WREADY) w_wait++;
      w_stl = M_AXI_WVALID && !M_AXI_WREADY;
      wdata_p = M_AXI_WDATA; wlast_p = M_AXI_WLAST;
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        checks++;
        if (exp_w.size() == 0) begin
          errors++; $display("FAIL w_extra: unexpected W beat word0=%h", M_AXI_WDATA[31:0]);
        end else begin
          ew = exp_w.pop_front();
          exp_data = {(DW/32){ew.word}};
          if ({M_AXI_WDATA, M_AXI_WLAST, M_AXI_WSTRB} !== {exp_data, ew.last, {(DW/8){1'b1}}}) begin
            errors++;
            $display("FAIL w_beat%0d: got word0=%h word15=%h last=%b strb_ones=%b required word=%h last=%b",
                     w_beats, M_AXI_WDATA[31:0], M_AXI_WDATA[DW-1 -: 32], M_AXI_WLAST, &M_AXI_WSTRB, ew.word, ew.last);
          end
        end
        w_beats++;
        if (w_beats == int'(blen) + 1) b_pending = 1;
      end

      // AR channel
      if (ar_stl && !done) begin
        checks++;
        if (!M_AXI_ARVALID || M_AXI_ARADDR !== ar_addr_p) begin
          errors++;
          $display("FAIL ar_stable: valid=%b addr=%h required valid=1 addr=%h", M_AXI_ARVALID, M_AXI_ARADDR, ar_addr_p);
        end
      end
      M_AXI_ARREADY = M_AXI_ARVALID && (ar_wait >= stall);
      if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_wait++;
      ar_stl = M_AXI_ARVALID && !M_AXI_ARREADY;
      ar_addr_p = M_AXI_ARADDR;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        checks++;
        if (exp_ar.size() == 0) begin
          errors++; $display("FAIL ar_extra: unexpected AR handshake addr=%h", M_AXI_ARADDR);
        end else begin
          ea = exp_ar.pop_front();
          if ({M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST} !== {ea.addr, ea.len, 3'd6, 2'b01}) begin
            errors++;
            $display("FAIL ar_payload: got addr=%h len=%0d size=%0d burst=%0d required addr=%h len=%0d size=6 burst=1",
                     M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, ea.addr, ea.len);
          end
        end
        r_pending = 1; r_beat = 0;
      end
    end
    idle_slave();
    if (!reset_hit && done_at < 0) begin
      checks++; errors++;
      $display("FAIL done_wait: no done within %0d cycles, required done pulse", max_cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; base_addr = '0; burst_len = '0;
    idle_slave(); set_defaults();
    repeat (2) @(negedge clk);
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, busy, done, err_flags, cycles} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b busy=%b done=%b flags=%b cycles=%0d required all 0",
               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, busy, done, err_flags, cycles);
    end
    checks++;
    if ({M_AXI_AWID, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS,
         M_AXI_ARID, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS} !== '0) begin
      errors++; $display("FAIL sideband_zero: AW/AR sideband outputs nonzero, required 0");
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, M_AXI_AWVALID} !== 3'b000) begin
      errors++; $display("FAIL idle_no_start: busy=%b done=%b awvalid=%b required 000", busy, done, M_AXI_AWVALID);
    end
  endtask

  task automatic test_basic();
    set_defaults();
    run_txn(64'h1000, 8'd3, 200);
    checks++;
    if (done_cnt != 1 || flags_seen !== 4'b0000) begin
      errors++; $display("FAIL basic_done: done_cnt=%0d flags=%b required 1 / 0000", done_cnt, flags_seen);
    end
    checks++;
    if (exp_w.size() != 0 || exp_aw.size() != 0 || exp_ar.size() != 0 || r_beats != 4) begin
      errors++; $display("FAIL basic_beats: w_left=%0d aw_left=%0d ar_left=%0d r_beats=%0d required 0/0/0/4",
                         exp_w.size(), exp_aw.size(), exp_ar.size(), r_beats);
    end
    checks++;
    if (cycles_seen !== 32'(busy_cnt) || busy !== 1'b0) begin
      errors++; $display("FAIL basic_cycles: cycles=%0d busy=%b required %0d / 0", cycles_seen, busy, busy_cnt);
    end
  endtask

  task automatic test_stall();
    set_defaults();
    stall = 5; extra_start = 1;
    run_txn(64'h0000_0001_2345_6780, 8'd0, 300);
    checks++;
    if (done_cnt != 1 || flags_seen !== 4'b0000) begin
      errors++; $display("FAIL stall_done: done_cnt=%0d flags=%b required 1 / 0000", done_cnt, flags_seen);
    end
    checks++;
    if (exp_w.size() != 0 || exp_ar.size() != 0 || r_beats != 1) begin
      errors++; $display("FAIL stall_beats: w_left=%0d ar_left=%0d r_beats=%0d required 0/0/1", exp_w.size(), exp_ar.size(), r_beats);
    end
    checks++;
    if (cycles_seen !== 32'(busy_cnt)) begin
      errors++; $display("FAIL stall_cycles: cycles=%0d required %0d", cycles_seen, busy_cnt);
    end
  endtask

  task automatic test_rlast();
    set_defaults();
    rlast_all = 1;
    run_txn(64'h4000, 8'd7, 300);
    checks++;
    if (done_cnt != 1 || flags_seen !== 4'b0100 || r_beats != 8) begin
      errors++; $display("FAIL rlast_err: done_cnt=%0d flags=%b r_beats=%0d required 1 / 0100 / 8", done_cnt, flags_seen, r_beats);
    end
  endtask

  task automatic test_resp_err();
    set_defaults();
    bresp_val = 2'b10; rresp_val = 2'b11;
    run_txn(64'h8000, 8'd1, 200);
    checks++;
    if (done_cnt != 1 || flags_seen !== 4'b0011) begin
      errors++; $display("FAIL resp_err: done_cnt=%0d flags=%b required 1 / 0011", done_cnt, flags_seen);
    end
  endtask

  task automatic test_timeout();
    set_defaults();
    awready_never = 1;
    run_txn(64'hA000, 8'd2, 100);
    checks++;
    if (done_cnt != 1 || flags_seen !== 4'b1000) begin
      errors++; $display("FAIL timeout_flag: done_cnt=%0d flags=%b required 1 / 1000", done_cnt, flags_seen);
    end
    checks++;
    if (done_at - aw_first != 16 || cycles_seen !== 32'd16) begin
      errors++; $display("FAIL timeout_latency: done after %0d cycles cycles=%0d required 16 / 16", done_at - aw_first, cycles_seen);
    end
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, busy} !== 3'b000) begin
      errors++; $display("FAIL timeout_drop: awvalid=%b wvalid=%b busy=%b required 000", M_AXI_AWVALID, M_AXI_WVALID, busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    set_defaults();
    reset_beat = 2;
    run_txn(64'h2000, 8'd3, 200);
    checks++;
    if (!reset_hit) begin
      errors++; $display("FAIL reset_mid_reach: W beat 2 never offered, required reset point reached");
    end
    @(negedge clk);
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
         busy, done, err_flags, cycles} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: aw=%b w=%b b=%b ar=%b r=%b busy=%b done=%b flags=%b cycles=%0d required all 0",
               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, busy, done, err_flags, cycles);
    end
    repeat (2) @(negedge clk) if (done) seen_done++;
    reset = 1'b0;
    repeat (3) @(negedge clk) if (done) seen_done++;
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL reset_mid_nodone: done pulses=%0d required 0", seen_done);
    end
    set_defaults();
    run_txn(64'h3000, 8'd3, 200);
    checks++;
    if (done_cnt != 1 || flags_seen !== 4'b0000 || exp_w.size() != 0 || r_beats != 4) begin
      errors++; $display("FAIL reset_mid_rerun: done_cnt=%0d flags=%b w_left=%0d r_beats=%0d required 1/0000/0/4",
                         done_cnt, flags_seen, exp_w.size(), r_beats);
    end
  endtask

  task automatic test_max_len();
    set_defaults();
    run_txn(64'h0000_0000_FFFF_FF80, 8'd255, 1500);
    checks++;
    if (done_cnt != 1 || flags_seen !== 4'b0000 || r_beats != 256) begin
      errors++; $display("FAIL maxlen_done: done_cnt=%0d flags=%b r_beats=%0d required 1/0000/256", done_cnt, flags_seen, r_beats);
    end
    checks++;
    if (exp_w.size() != 0 || exp_ar.size() != 0 || cycles_seen !== 32'(busy_cnt)) begin
      errors++; $display("FAIL maxlen_beats: w_left=%0d ar_left=%0d cycles=%0d required 0/0/%0d",
                         exp_w.size(), exp_ar.size(), cycles_seen, busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_rlast();
    test_resp_err();
    test_timeout();
    test_reset_mid();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
